mcb_port_arbiter: RTL and testbench
===================================

// Module: mcb_port_arbiter
// PURPOSE
//  Sequencer and arbiter for the single LPDDR MCB port p0, shared by three requesters: video line
//  fetch, cache line writeback and cache line refill. It issues MCB commands, moves burst data
//  between the MCB FIFOs and the cache/video buffers, and reports busy status to each requester.
//  It sits in the mem_clk domain between cache_64k, VID and the lpddr wrapper.
// PARAMETERS
//  VID_BL      64      words (128-bit) per video burst; cmd_bl = VID_BL-1
//  VID_BURSTS  2       bursts per video request, address advancing by VID_STRIDE
//  VID_STRIDE  'h400   byte-address increment between video bursts
//  LINE_BL     16      words (128-bit) per cache line; cmd_bl = LINE_BL-1
//  STARVE_MAX  4       consecutive video grants allowed while a cache request is waiting
// PORTS
//  clk             in   1    memory clock (mem_clk); all logic on its rising edge
//  rst             in   1    asynchronous, active-low reset
//  calib_done      in   1    MCB calibration complete; no grant issued while low
//  vid_req         in   1    video fetch request, level, async to clk
//  vid_raddr       in   20   video fetch address [23:4]
//  wr_req / rd_req in   1    cache writeback / refill request, level, async to clk
//  waddr / raddr   in   16   cache line address [23:8]
//  vid_busy, wr_busy, rd_busy  out 1   per-requester busy
//  vid_we          out  1    video buffer write strobe; vid_addr out 7 video buffer word index
//  cache_en, cache_we          out 1   cache port strobe / write-select (0 = read for writeback)
//  cache_addr      out  4    cache line word index
//  buf_wdata       out  128  registered p0_rd_data, shared by video and cache buffers
//  p0_cmd_en, p0_cmd_instr[3], p0_cmd_byte_addr[30], p0_cmd_bl[6]   out   MCB command port
//  p0_wr_en, p0_rd_en          out 1   MCB write / read FIFO strobes
//  p0_rd_data      in   128  read FIFO data;  p0_rd_empty, p0_wr_empty in 1 FIFO flags
// BEHAVIOUR
//  Reset: all outputs, counters and sync flops 0; state IDLE. While calib_done is low the block
//   is held in that state (synchronous hold).
//  Sync: each *_req passes through one clk flop. Grant is decided in IDLE from the synced value,
//   so the minimum latency from request to p0_cmd_en (read) or cache_en (writeback) is 2 cycles.
//  Priority in IDLE: video > writeback (only if p0_wr_empty) > refill. Exception: when the starve
//   count equals STARVE_MAX and a synced wr/rd request is pending, the cache request wins.
//   The starve count increments on each video grant while a cache request is pending and clears
//   on any cache grant or when no cache request is pending. It saturates at STARVE_MAX.
//  Command address: video {6'd0, vid_raddr, 4'd0}; cache {6'd0, addr, 8'd0}.
//   Reads use instr 3'b001 and write commands use 3'b000. Commands are single-cycle p0_cmd_en pulses.
//  States:
//   IDLE   busy flags 0; on grant raise the matching busy, reset word counters -> VCMD/WFILL/RCMD
//   VCMD   p0_cmd_en pulse, bl=VID_BL-1 -> VWAIT
//   VWAIT  wait for ~p0_rd_empty; assert p0_rd_en -> VXFER
//   VXFER  a word transfers on each cycle with p0_rd_en & ~p0_rd_empty. That cycle: buf_wdata
//          <= p0_rd_data, and vid_we pulses with vid_addr (incremented after each write).
//          After VID_BL words: drop rd_en. If bursts < VID_BURSTS, go to VCMD with
//          addr += VID_STRIDE; otherwise go to DONE.
//   WFILL  cache_en=1, cache_we=0 for LINE_BL consecutive cycles. cache_addr is 0..LINE_BL-1,
//          and p0_wr_en follows one cycle later. Then -> WCMD.
//   WCMD   p0_cmd_en pulse, bl=LINE_BL-1; wr_busy cleared here -> WDRAIN
//   WDRAIN wait for p0_wr_empty -> IDLE
//   RCMD/RWAIT/RXFER  same as the video states, with LINE_BL words. Each word drives cache_en=1,
//          cache_we=1 and cache_addr. Then -> DONE.
//   DONE   clear busy -> IDLE (one cycle)
//  Counters: vid_addr wraps 127->0 (exactly 2x64 words per request). cache_addr wraps 15->0.
//   Byte address arithmetic is modulo 2^30.
//  Read FIFO empty mid-burst: stall. No strobe is issued and the counter is held. There is no timeout.
//  A requester deasserting mid-transaction does not abort; the transaction completes.
//  Simultaneous requests: resolved only in IDLE; a losing request stays pending.
//  Async reset mid-burst: immediate return to IDLE with outputs 0. MCB FIFO cleanup is the
//   system's responsibility.
// TESTING
//  1 Reset/calib: rst=0 then 1 with calib_done=0, vid_req=1 -> no p0_cmd_en until calib_done=1;
//    first cmd 2 cycles after calib_done, and all outputs 0 during reset.
//  2 Video: vid_raddr=20'h0E7F0 -> cmds at 0x00E7F00 then 0x00E8300 with bl=63. Exactly 128
//    vid_we pulses, vid_addr 0..127, data matches the FIFO model.
//  3 Writeback: waddr=16'h1234 -> 16 cache reads at cache_addr 0..15, then 16 p0_wr_en, then one
//    cmd with instr=000, addr=0x0123400, bl=15. wr_busy falls at cmd; IDLE after wr_empty.
//  4 Refill with rd_empty toggled every other cycle -> 16 cache writes in order with no
//    duplicates or drops; addr=raddr<<8, bl=15.
//  5 Priority/starvation: vid_req and rd_req held high -> refill granted after 4 video grants;
//    wr_req + rd_req together -> write serviced first.
//  6 Async reset in VXFER at word 30 -> all strobes 0 immediately, IDLE, busy=0.

Source files
------------

// File: rtl/mcb_port_arbiter.sv
// Shares MCB port p0 among video fetch, cache writeback and cache refill. Grant lands 2 cycles after a request.
// Read bursts stall word-by-word on p0_rd_empty; writeback waits for p0_wr_empty before it is granted and before returning to IDLE.
module mcb_port_arbiter #(
   parameter int          VID_BL     = 64,
   parameter int          VID_BURSTS = 2,
   parameter logic [29:0] VID_STRIDE = 30'h400,
   parameter int          LINE_BL    = 16,
   parameter int          STARVE_MAX = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         calib_done,
   input  logic         vid_req,
   input  logic [19:0]  vid_raddr,
   input  logic         wr_req,
   input  logic [15:0]  waddr,
   input  logic         rd_req,
   input  logic [15:0]  raddr,
   output logic         vid_busy,
   output logic         wr_busy,
   output logic         rd_busy,
   output logic         vid_we,
   output logic [6:0]   vid_addr,
   output logic         cache_en,
   output logic         cache_we,
   output logic [3:0]   cache_addr,
   output logic [127:0] buf_wdata,
   output logic         p0_cmd_en,
   output logic [2:0]   p0_cmd_instr,
   output logic [29:0]  p0_cmd_byte_addr,
   output logic [5:0]   p0_cmd_bl,
   output logic         p0_wr_en,
   output logic         p0_rd_en,
   input  logic [127:0] p0_rd_data,
   input  logic         p0_rd_empty,
   input  logic         p0_wr_empty
);

   localparam logic [6:0] VID_LAST    = 7'(VID_BL - 1);
   localparam logic [6:0] LINE_LAST   = 7'(LINE_BL - 1);
   localparam logic [3:0] CADDR_LAST  = 4'(LINE_BL - 1);
   localparam logic [1:0] BURST_LAST  = 2'(VID_BURSTS - 1);
   localparam logic [2:0] STARVE_TOP  = 3'(STARVE_MAX);
   localparam logic [5:0] VID_CMD_BL  = 6'(VID_BL - 1);
   localparam logic [5:0] LINE_CMD_BL = 6'(LINE_BL - 1);

   typedef enum logic [3:0] {
      IDLE, VCMD, VWAIT, VXFER, WFILL, WCMD, WDRAIN, RCMD, RWAIT, RXFER, DONE
   } state_t;

   state_t      state, state_nxt;
   logic        calib_s, vid_s, wr_s, rd_s;
   logic [2:0]  starve;
   logic [6:0]  cnt;
   logic [1:0]  burst;
   logic        cache_wr;
   logic        xfer;
   logic        grant_vid, grant_wr, grant_rd;
   logic        burst_end;
   logic        wr_ok, cache_first;

   assign p0_rd_en     = (state == VXFER) || (state == RXFER);
   assign xfer         = p0_rd_en && !p0_rd_empty;
   assign p0_cmd_en    = (state == VCMD) || (state == WCMD) || (state == RCMD);
   assign p0_cmd_instr = ((state == VCMD) || (state == RCMD)) ? 3'b001 : 3'b000;
   assign p0_cmd_bl    = (state == VCMD) ? VID_CMD_BL :
                         ((state == WCMD) || (state == RCMD)) ? LINE_CMD_BL : 6'd0;
   assign vid_busy     = (state == VCMD) || (state == VWAIT) || (state == VXFER);
   assign wr_busy      = (state == WFILL);
   assign rd_busy      = (state == RCMD) || (state == RWAIT) || (state == RXFER);
   assign cache_en     = (state == WFILL) || cache_wr;
   assign cache_we     = cache_wr;

   always_comb begin
      state_nxt   = state;
      grant_vid   = 1'b0;
      grant_wr    = 1'b0;
      grant_rd    = 1'b0;
      burst_end   = 1'b0;
      wr_ok       = wr_s && p0_wr_empty;
      cache_first = (starve == STARVE_TOP) && (wr_ok || rd_s);
      case (state)
         IDLE: begin
            if (calib_s) begin
               if (vid_s && !cache_first) begin
                  grant_vid = 1'b1;
                  state_nxt = VCMD;
               end else if (wr_ok) begin
                  grant_wr  = 1'b1;
                  state_nxt = WFILL;
               end else if (rd_s) begin
                  grant_rd  = 1'b1;
                  state_nxt = RCMD;
               end
            end
         end
         VCMD:   state_nxt = VWAIT;
         VWAIT:  if (!p0_rd_empty) state_nxt = VXFER;
         VXFER: begin
            if (xfer && (cnt == VID_LAST)) begin
               burst_end = 1'b1;
               state_nxt = (burst == BURST_LAST) ? DONE : VCMD;
            end
         end
         WFILL:  if (cache_addr == CADDR_LAST) state_nxt = WCMD;
         WCMD:   state_nxt = WDRAIN;
         WDRAIN: if (p0_wr_empty) state_nxt = IDLE;
         RCMD:   state_nxt = RWAIT;
         RWAIT:  if (!p0_rd_empty) state_nxt = RXFER;
         RXFER:  if (xfer && (cnt == LINE_LAST)) state_nxt = DONE;
         DONE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         calib_s <= 1'b0;
         vid_s   <= 1'b0;
         wr_s    <= 1'b0;
         rd_s    <= 1'b0;
      end else begin
         calib_s <= calib_done;
         vid_s   <= vid_req;
         wr_s    <= wr_req;
         rd_s    <= rd_req;
      end
   end

   // Video may win at most STARVE_MAX times in a row over a waiting cache request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                              starve <= 3'd0;
      else if (!(wr_s || rd_s))              starve <= 3'd0;
      else if (grant_wr || grant_rd)         starve <= 3'd0;
      else if (grant_vid && (starve != STARVE_TOP)) starve <= starve + 3'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p0_cmd_byte_addr <= 30'd0;
         cnt              <= 7'd0;
         burst            <= 2'd0;
      end else begin
         if (grant_vid)      p0_cmd_byte_addr <= {6'd0, vid_raddr, 4'd0};
         else if (grant_wr)  p0_cmd_byte_addr <= {6'd0, waddr, 8'd0};
         else if (grant_rd)  p0_cmd_byte_addr <= {6'd0, raddr, 8'd0};
         else if (burst_end && (burst != BURST_LAST))
            p0_cmd_byte_addr <= p0_cmd_byte_addr + VID_STRIDE;

         if (grant_vid || grant_wr || grant_rd) cnt <= 7'd0;
         else if (burst_end)                    cnt <= 7'd0;
         else if (xfer)                         cnt <= (state == RXFER && cnt == LINE_LAST) ? 7'd0 : cnt + 7'd1;

         if (grant_vid)      burst <= 2'd0;
         else if (burst_end) burst <= burst + 2'd1;
      end
   end

   // Buffer strobes trail the FIFO pop by one cycle so they line up with buf_wdata.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_wdata  <= 128'd0;
         vid_we     <= 1'b0;
         cache_wr   <= 1'b0;
         vid_addr   <= 7'd0;
         cache_addr <= 4'd0;
         p0_wr_en   <= 1'b0;
      end else begin
         if (xfer) buf_wdata <= p0_rd_data;
         vid_we   <= xfer && (state == VXFER);
         cache_wr <= xfer && (state == RXFER);
         p0_wr_en <= (state == WFILL);

         if (grant_vid)   vid_addr <= 7'd0;
         else if (vid_we) vid_addr <= vid_addr + 7'd1;

         if (grant_wr || grant_rd) cache_addr <= 4'd0;
         else if (cache_en)        cache_addr <= cache_addr + 4'd1;
      end
   end

   a_cmd_pulse: assert property (@(posedge clk) disable iff (!rst) p0_cmd_en |=> !p0_cmd_en);
   a_one_buf:   assert property (@(posedge clk) disable iff (!rst) !(vid_we && cache_we));
   a_calib:     assert property (@(posedge clk) disable iff (!rst)
                                 (state == IDLE && !calib_s) |=> (state == IDLE));

endmodule

// File: tb/tb_mcb_port_arbiter.sv
// Scoreboard bench for mcb_port_arbiter with a small MCB FIFO model driven on the falling edge.
module tb_mcb_port_arbiter;

   logic         clk, rst, calib_done;
   logic         vid_req, wr_req, rd_req;
   logic [19:0]  vid_raddr;
   logic [15:0]  waddr, raddr;
   logic         vid_busy, wr_busy, rd_busy, vid_we, cache_en, cache_we;
   logic [6:0]   vid_addr;
   logic [3:0]   cache_addr;
   logic [127:0] buf_wdata, p0_rd_data;
   logic         p0_cmd_en, p0_wr_en, p0_rd_en, p0_rd_empty, p0_wr_empty;
   logic [2:0]   p0_cmd_instr;
   logic [29:0]  p0_cmd_byte_addr;
   logic [5:0]   p0_cmd_bl;

   mcb_port_arbiter dut (
      .clk(clk), .rst(rst), .calib_done(calib_done),
      .vid_req(vid_req), .vid_raddr(vid_raddr),
      .wr_req(wr_req), .waddr(waddr), .rd_req(rd_req), .raddr(raddr),
      .vid_busy(vid_busy), .wr_busy(wr_busy), .rd_busy(rd_busy),
      .vid_we(vid_we), .vid_addr(vid_addr),
      .cache_en(cache_en), .cache_we(cache_we), .cache_addr(cache_addr),
      .buf_wdata(buf_wdata),
      .p0_cmd_en(p0_cmd_en), .p0_cmd_instr(p0_cmd_instr),
      .p0_cmd_byte_addr(p0_cmd_byte_addr), .p0_cmd_bl(p0_cmd_bl),
      .p0_wr_en(p0_wr_en), .p0_rd_en(p0_rd_en),
      .p0_rd_data(p0_rd_data), .p0_rd_empty(p0_rd_empty), .p0_wr_empty(p0_wr_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [38:0]  cmdq[$];   // {instr, byte_addr, bl}
   logic [134:0] vidq[$];   // {vid_addr, data}
   logic [131:0] rfq[$];    // {cache_addr, data}
   logic [3:0]   cwq[$];    // cache read addresses
   logic [127:0] rdq[$];    // read FIFO contents
   int  cmd_cnt = 0, vid_cnt = 0, wren_cnt = 0, wr_fill = 0;
   bit  stall_mode = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] mk_word(input logic [29:0] a, input int i);
      return {2'b00, a, 32'(i), ~{2'b00, a}, 32'hDA7A0000 + 32'(i)};
   endfunction

   task automatic push_vid(input logic [19:0] r);
      logic [29:0] a;
      for (int b = 0; b < 2; b++) begin
         a = {6'd0, r, 4'd0} + 30'(b) * 30'h400;
         cmdq.push_back({3'b001, a, 6'd63});
         for (int i = 0; i < 64; i++) vidq.push_back({7'(b * 64 + i), mk_word(a, i)});
      end
   endtask

   task automatic push_wr(input logic [15:0] w);
      cmdq.push_back({3'b000, 6'd0, w, 8'd0, 6'd15});
      for (int i = 0; i < 16; i++) cwq.push_back(4'(i));
   endtask

   task automatic push_rd(input logic [15:0] r);
      logic [29:0] a;
      a = {6'd0, r, 8'd0};
      cmdq.push_back({3'b001, a, 6'd15});
      for (int i = 0; i < 16; i++) rfq.push_back({4'(i), mk_word(a, i)});
   endtask

   // MCB FIFO model and output scoreboard; inputs change only on the falling edge.
   initial begin
      logic [134:0] ev;
      logic [131:0] er;
      logic [38:0]  ec;
      logic [3:0]   ea;
      bit pend_pop, drain, tog;
      pend_pop = 0; drain = 0; tog = 0;
      p0_rd_empty = 1'b1; p0_wr_empty = 1'b1; p0_rd_data = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            cmdq.delete(); vidq.delete(); rfq.delete(); cwq.delete(); rdq.delete();
            pend_pop = 0; drain = 0; wr_fill = 0;
            p0_rd_empty = 1'b1; p0_wr_empty = 1'b1; p0_rd_data = '0;
         end else begin
            if (pend_pop && rdq.size() > 0) void'(rdq.pop_front());
            if (drain) begin
               if (wr_fill > 0) wr_fill--;
               else drain = 0;
            end
            if (p0_wr_en) begin wr_fill++; wren_cnt++; end
            if (p0_cmd_en) begin
               cmd_cnt++;
               check("cmd_expected", 1'(cmdq.size() != 0), 1'b1);
               if (cmdq.size() != 0) begin
                  ec = cmdq.pop_front();
                  check("cmd", {p0_cmd_instr, p0_cmd_byte_addr, p0_cmd_bl}, ec);
               end
               if (p0_cmd_instr == 3'b001) begin
                  for (int i = 0; i <= int'(p0_cmd_bl); i++) rdq.push_back(mk_word(p0_cmd_byte_addr, i));
               end else begin
                  check("wr_busy_at_cmd", wr_busy, 1'b0);
                  check("wr_words_at_cmd", wr_fill, 16);
                  drain = 1;
               end
            end
            if (vid_we) begin
               vid_cnt++;
               check("vid_we_expected", 1'(vidq.size() != 0), 1'b1);
               if (vidq.size() != 0) begin
                  ev = vidq.pop_front();
                  check("vid_addr", vid_addr, ev[134:128]);
                  check("vid_data", buf_wdata, ev[127:0]);
               end
            end
            if (cache_en && cache_we) begin
               check("cache_wr_expected", 1'(rfq.size() != 0), 1'b1);
               if (rfq.size() != 0) begin
                  er = rfq.pop_front();
                  check("cache_wr_addr", cache_addr, er[131:128]);
                  check("cache_wr_data", buf_wdata, er[127:0]);
               end
            end
            if (cache_en && !cache_we) begin
               check("cache_rd_expected", 1'(cwq.size() != 0), 1'b1);
               if (cwq.size() != 0) begin
                  ea = cwq.pop_front();
                  check("cache_rd_addr", cache_addr, ea);
               end
            end
            tog = !tog;
            p0_rd_empty = (rdq.size() == 0) || (stall_mode && tog);
            p0_rd_data  = (rdq.size() != 0) ? rdq[0] : '0;
            p0_wr_empty = (wr_fill == 0);
            pend_pop    = p0_rd_en && !p0_rd_empty;
         end
      end
   end

   task automatic wait_idle(input string tag, input int budget);
      int k;
      k = 0;
      while (k < budget && (cmdq.size() != 0 || vidq.size() != 0 || rfq.size() != 0 ||
             cwq.size() != 0 || vid_busy || wr_busy || rd_busy || wr_fill != 0)) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_in_time"}, 1'(k < budget), 1'b1);
      check({tag, "_left"}, cmdq.size() + vidq.size() + rfq.size() + cwq.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_busy(input string tag, input int which, input int budget);
      int k;
      k = 0;
      while (k < budget && !((which == 0 && vid_busy) || (which == 1 && wr_busy) ||
                             (which == 2 && rd_busy))) begin
         @(negedge clk);
         k++;
      end
      check(tag, 1'(k < budget), 1'b1);
   endtask

   initial begin
      int n, base;
      rst = 1'b0; calib_done = 1'b0;
      vid_req = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
      vid_raddr = 20'h00010; waddr = '0; raddr = '0;

      // Reset and calibration hold
      repeat (3) @(negedge clk);
      check("rst_cmd", {p0_cmd_en, p0_cmd_instr, p0_cmd_bl}, 0);
      check("rst_addr", p0_cmd_byte_addr, 0);
      check("rst_busy", {vid_busy, wr_busy, rd_busy}, 0);
      check("rst_cache", {cache_en, cache_we, cache_addr}, 0);
      check("rst_vid", {vid_we, vid_addr}, 0);
      check("rst_fifo_strobes", {p0_rd_en, p0_wr_en}, 0);
      check("rst_buf", buf_wdata, 0);
      rst = 1'b1;
      push_vid(20'h00010);
      repeat (8) @(negedge clk);
      check("calib_hold_cmds", cmd_cnt, 0);
      calib_done = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!p0_cmd_en && n < 10);
      check("calib_to_cmd_cycles", n, 2);
      vid_req = 1'b0;
      wait_idle("t1", 1000);

      // Video fetch, two bursts
      base = vid_cnt;
      vid_raddr = 20'h0E7F0;
      push_vid(vid_raddr);
      vid_req = 1'b1;
      wait_busy("t2_grant", 0, 20);
      vid_req = 1'b0;
      wait_idle("t2", 1000);
      check("t2_vid_we_count", vid_cnt - base, 128);

      // Writeback
      base = wren_cnt;
      waddr = 16'h1234;
      push_wr(waddr);
      wr_req = 1'b1;
      wait_busy("t3_grant", 1, 20);
      wr_req = 1'b0;
      wait_idle("t3", 200);
      check("t3_wr_en_count", wren_cnt - base, 16);

      // Refill with the read FIFO stalling every other cycle
      stall_mode = 1;
      raddr = 16'hBEEF;
      push_rd(raddr);
      rd_req = 1'b1;
      wait_busy("t4_grant", 2, 20);
      rd_req = 1'b0;
      wait_idle("t4", 300);
      stall_mode = 0;

      // Starvation limit: four video grants, then the refill
      vid_raddr = 20'h00100;
      raddr = 16'h0777;
      for (int i = 0; i < 4; i++) push_vid(vid_raddr);
      push_rd(raddr);
      vid_req = 1'b1; rd_req = 1'b1;
      wait_busy("t5_refill_grant", 2, 3000);
      vid_req = 1'b0; rd_req = 1'b0;
      wait_idle("t5a", 300);

      // Writeback beats refill when both are pending
      waddr = 16'h0ABC; raddr = 16'h0DEF;
      push_wr(waddr);
      push_rd(raddr);
      wr_req = 1'b1; rd_req = 1'b1;
      wait_busy("t5_wr_first", 1, 20);
      check("t5_rd_waits", rd_busy, 1'b0);
      wr_req = 1'b0;
      wait_busy("t5_rd_after", 2, 200);
      rd_req = 1'b0;
      wait_idle("t5b", 300);

      // Asynchronous reset in the middle of a video transfer
      base = vid_cnt;
      vid_raddr = 20'h12345;
      push_vid(vid_raddr);
      vid_req = 1'b1;
      n = 0;
      while (vid_cnt - base < 30 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("t6_reach_word30", 1'(n < 500), 1'b1);
      vid_req = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("t6_cmd", p0_cmd_en, 1'b0);
      check("t6_fifo_strobes", {p0_rd_en, p0_wr_en}, 0);
      check("t6_buf_strobes", {vid_we, cache_en, cache_we}, 0);
      check("t6_busy", {vid_busy, wr_busy, rd_busy}, 0);
      check("t6_vid_addr", vid_addr, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      base = cmd_cnt;
      repeat (6) @(negedge clk);
      check("t6_idle_cmds", cmd_cnt - base, 0);
      check("t6_idle_busy", {vid_busy, wr_busy, rd_busy}, 0);
      raddr = 16'h0042;
      push_rd(raddr);
      rd_req = 1'b1;
      wait_busy("t6_recover_grant", 2, 20);
      rd_req = 1'b0;
      wait_idle("t6", 300);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
